// File: rtl/clb_cfg_pkg.sv
// Shared types and constants for the CLB configuration loader.
// The loader state enum and the scan-chain length helper live here.
package clb_cfg_pkg;

  localparam int CLB_CONFIG_SIZE = 37;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } cfg_state_e;

  // Total number of scan-chain bits across all chained CLBs.
  function automatic int chain_len(input int num_clbs, input int config_size);
    return num_clbs * config_size;
  endfunction

endpackage

// File: rtl/clb_cfg_loader_shift_buf.sv
// Parallel-load shift register that presents one configuration word MSB-first,
// with a bit counter that flags the last bit so a new word can load seamlessly.
module cfg_shift_buf #(
  parameter int CONFIG_SIZE = 37
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   shift,
  input  logic [CONFIG_SIZE-1:0] load_data,
  output logic                   msb,
  output logic                   empty,
  output logic                   last_bit
);

  localparam int CW = $clog2(CONFIG_SIZE);
  localparam logic [CW-1:0] LAST = CW'(CONFIG_SIZE - 1);

  logic [CONFIG_SIZE-1:0] sreg;
  logic [CW-1:0]          bit_cnt;
  logic                   full;

  always_ff @(posedge clk) begin
    if (reset) begin
      full    <= 1'b0;
      bit_cnt <= '0;
    end else if (load) begin
      full    <= 1'b1;
      bit_cnt <= '0;
    end else if (shift && full) begin
      if (bit_cnt == LAST) full <= 1'b0;
      else                 bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Data path carries no reset; the full flag alone qualifies it.
  always_ff @(posedge clk) begin
    if (load)
      sreg <= load_data;
    else if (shift && full)
      sreg <= {sreg[CONFIG_SIZE-2:0], 1'b0};
  end

  assign msb      = full & sreg[CONFIG_SIZE-1];
  assign empty    = ~full;
  assign last_bit = full && (bit_cnt == LAST);

endmodule

// File: rtl/clb_cfg_loader.sv
// Configuration sequencer for a daisy-chain of CLBs: serialises one word per CLB
// onto the chain head, or flushes zeros through the whole chain on clear.
module clb_cfg_loader
  import clb_cfg_pkg::*;
#(
  parameter int CONFIG_SIZE = CLB_CONFIG_SIZE,
  parameter int NUM_CLBS    = 4
) (
  input  logic                          cfg_clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          clear,
  input  logic                          word_valid,
  input  logic [CONFIG_SIZE-1:0]        word_data,
  output logic                          word_ready,
  output logic                          cfg_en,
  output logic                          cfg_out,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NUM_CLBS+1)-1:0] words_loaded
);

  localparam int WW    = $clog2(NUM_CLBS + 1);
  localparam int CHAIN = chain_len(NUM_CLBS, CONFIG_SIZE);
  localparam int CCW   = $clog2(CHAIN + 1);

  localparam logic [WW-1:0]  NUM_W     = WW'(NUM_CLBS);
  localparam logic [WW-1:0]  LAST_WORD = WW'(NUM_CLBS - 1);
  localparam logic [CCW-1:0] CLR_LAST  = CCW'(CHAIN - 1);

  cfg_state_e     state;
  logic [WW-1:0]  acc_cnt;
  logic [CCW-1:0] clr_cnt;
  logic           in_load;
  logic           accept;
  logic           buf_msb;
  logic           buf_empty;
  logic           buf_last;

  assign in_load    = (state == LOAD);
  assign word_ready = in_load && (buf_empty || buf_last) && (acc_cnt < NUM_W);
  assign accept     = word_ready && word_valid;

  cfg_shift_buf #(
    .CONFIG_SIZE(CONFIG_SIZE)
  ) u_shift_buf (
    .clk      (cfg_clk),
    .reset    (reset),
    .load     (accept),
    .shift    (in_load),
    .load_data(word_data),
    .msb      (buf_msb),
    .empty    (buf_empty),
    .last_bit (buf_last)
  );

  assign cfg_en  = (in_load && !buf_empty) || (state == CLEAR);
  assign cfg_out = in_load && buf_msb;

  always_ff @(posedge cfg_clk) begin
    if (reset) begin
      state        <= IDLE;
      acc_cnt      <= '0;
      clr_cnt      <= '0;
      words_loaded <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            state        <= CLEAR;
            clr_cnt      <= '0;
            words_loaded <= '0;
            busy         <= 1'b1;
          end else if (start) begin
            state        <= LOAD;
            acc_cnt      <= '0;
            words_loaded <= '0;
            busy         <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) acc_cnt <= acc_cnt + 1'b1;
          // A word completes on the edge that shifts out its final bit.
          if (buf_last) begin
            words_loaded <= words_loaded + 1'b1;
            if (words_loaded == LAST_WORD) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Bench for clb_cfg_loader: one single-CLB and one four-CLB instance, with shadow
// scan-chain models fed by cfg_en/cfg_out and a word-level expected-bitstream model.
module tb_clb_cfg_loader;

  localparam int CS = 37;
  localparam int L4 = 4 * CS;

  logic clk;
  logic rst1, rst4;

  logic          start1, clear1, word_valid1;
  logic [CS-1:0] word_data1;
  logic          word_ready1, cfg_en1, cfg_out1, busy1, done1;
  logic [0:0]    words_loaded1;

  logic          start4, clear4, word_valid4;
  logic [CS-1:0] word_data4;
  logic          word_ready4, cfg_en4, cfg_out4, busy4, done4;
  logic [2:0]    words_loaded4;

  logic [CS-1:0] chain1;
  logic [L4-1:0] chain4;

  int errors;
  int checks;

  clb_cfg_loader #(.CONFIG_SIZE(CS), .NUM_CLBS(1)) dut1 (
    .cfg_clk(clk), .reset(rst1), .start(start1), .clear(clear1),
    .word_valid(word_valid1), .word_data(word_data1), .word_ready(word_ready1),
    .cfg_en(cfg_en1), .cfg_out(cfg_out1), .busy(busy1), .done(done1),
    .words_loaded(words_loaded1)
  );

  clb_cfg_loader #(.CONFIG_SIZE(CS), .NUM_CLBS(4)) dut4 (
    .cfg_clk(clk), .reset(rst4), .start(start4), .clear(clear4),
    .word_valid(word_valid4), .word_data(word_data4), .word_ready(word_ready4),
    .cfg_en(cfg_en4), .cfg_out(cfg_out4), .busy(busy4), .done(done4),
    .words_loaded(words_loaded4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shadow CLB chains: bit 0 is the nearest CLB's cfg_in end.
  always @(posedge clk) if (cfg_en1) chain1 <= {chain1[CS-2:0], cfg_out1};
  always @(posedge clk) if (cfg_en4) chain4 <= {chain4[L4-2:0], cfg_out4};

  task automatic test_reset();
    rst1 = 1'b1; rst4 = 1'b1;
    start1 = 0; clear1 = 0; word_valid1 = 0; word_data1 = '0;
    start4 = 0; clear4 = 0; word_valid4 = 0; word_data4 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cfg_en1, cfg_out1, word_ready1, busy1, done1, words_loaded1} !== 6'b0) begin
      $display("FAIL reset_n1 outputs got %b want 0", {cfg_en1, cfg_out1, word_ready1, busy1, done1, words_loaded1});
      errors++;
    end
    checks++;
    if ({cfg_en4, cfg_out4, word_ready4, busy4, done4, words_loaded4} !== 8'b0) begin
      $display("FAIL reset_n4 outputs got %b want 0", {cfg_en4, cfg_out4, word_ready4, busy4, done4, words_loaded4});
      errors++;
    end
    rst1 = 1'b0; rst4 = 1'b0;
    word_valid4 = 1'b1; word_data4 = 37'h1_FFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({cfg_en4, word_ready4, busy4, words_loaded4} !== 6'b0) begin
      $display("FAIL idle_valid_ignored got %b want 0", {cfg_en4, word_ready4, busy4, words_loaded4});
      errors++;
    end
    word_valid4 = 1'b0;
  endtask

  task automatic test_single();
    logic [CS-1:0] w;
    int acc_cyc, first_en, last_en, done_cyc, rdy_cycles, en_cnt, bad_out;
    bit fin;
    w = 37'h1_2345_6789;
    acc_cyc = -1; first_en = -1; last_en = -1; done_cyc = -1;
    rdy_cycles = 0; en_cnt = 0; bad_out = 0; fin = 0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    word_valid1 = 1'b1; word_data1 = w;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (done1) begin
        done_cyc = cyc; fin = 1;
      end else begin
        if (word_ready1) begin
          rdy_cycles++;
          if (word_valid1) acc_cyc = cyc;
        end
        if (cfg_en1) begin
          if (first_en < 0) first_en = cyc;
          last_en = cyc;
          if (en_cnt >= CS || cfg_out1 !== w[CS-1-en_cnt]) bad_out++;
          en_cnt++;
        end
      end
    end
    word_valid1 = 1'b0;
    checks++;
    if (!fin) begin $display("FAIL single_timeout got no done want done"); errors++; end
    checks++;
    if (rdy_cycles !== 1) begin $display("FAIL single_ready_cycles got %0d want 1", rdy_cycles); errors++; end
    checks++;
    if (en_cnt !== CS) begin $display("FAIL single_en_cycles got %0d want %0d", en_cnt, CS); errors++; end
    checks++;
    if (first_en !== acc_cyc + 1) begin $display("FAIL single_en_start got %0d want %0d", first_en, acc_cyc + 1); errors++; end
    checks++;
    if (last_en - first_en + 1 !== CS) begin $display("FAIL single_en_contig got span %0d want %0d", last_en - first_en + 1, CS); errors++; end
    checks++;
    if (bad_out !== 0) begin $display("FAIL single_bits got %0d wrong want 0", bad_out); errors++; end
    checks++;
    if (done_cyc !== last_en + 1) begin $display("FAIL single_done_cycle got %0d want %0d", done_cyc, last_en + 1); errors++; end
    @(negedge clk);
    checks++;
    if ({done1, busy1} !== 2'b00) begin $display("FAIL single_done_pulse got done/busy %b want 00", {done1, busy1}); errors++; end
    checks++;
    if (words_loaded1 !== 1'b1) begin $display("FAIL single_words_loaded got %0d want 1", words_loaded1); errors++; end
    checks++;
    if (chain1 !== w) begin $display("FAIL single_chain got %h want %h", chain1, w); errors++; end
  endtask

  task automatic load4(input logic [CS-1:0] w [4], input int stall_idx, input int stall_len,
                       input bit poke_start, input string tag);
    logic [L4-1:0] exp_chain;
    int acc, en_cnt, gap, first_en, done_seen, bad_out, bad_rdy, bad_busy, bad_wl, stall_left, exp_gap, cyc;
    bit fin, exp_rdy;
    logic [63:0] r64;
    for (int j = 0; j < 4; j++) exp_chain[(3 - j) * CS +: CS] = w[j];
    exp_gap = (stall_idx >= 1 && stall_idx <= 3) ? stall_len : 0;
    acc = 0; en_cnt = 0; gap = 0; first_en = -1; done_seen = 0;
    bad_out = 0; bad_rdy = 0; bad_busy = 0; bad_wl = 0; stall_left = stall_len;
    fin = 0; cyc = 0;
    @(negedge clk); start4 = 1'b1;
    while (!fin && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start4 = poke_start;
      if (done4) begin
        done_seen++; fin = 1; start4 = 1'b0; word_valid4 = 1'b0;
      end else begin
        if (busy4 !== 1'b1) bad_busy++;
        if (words_loaded4 !== 3'(en_cnt / CS)) bad_wl++;
        exp_rdy = (acc < 4) && (!cfg_en4 || (en_cnt % CS) == CS - 1);
        if (word_ready4 !== exp_rdy) bad_rdy++;
        if (cfg_en4) begin
          if (en_cnt >= L4) bad_out++;
          else if (cfg_out4 !== w[en_cnt / CS][CS - 1 - (en_cnt % CS)]) bad_out++;
          if (first_en < 0) first_en = cyc;
          en_cnt++;
        end else if (first_en >= 0) begin
          gap++;
        end
        r64 = {$urandom(), $urandom()};
        if (acc < 4 && word_ready4 && acc == stall_idx && stall_left > 0) begin
          word_valid4 = 1'b0; word_data4 = r64[CS-1:0]; stall_left--;
        end else if (acc < 4) begin
          word_valid4 = 1'b1; word_data4 = w[acc];
        end else begin
          word_valid4 = 1'b0; word_data4 = r64[CS-1:0];
        end
        if (word_valid4 && word_ready4) acc++;
      end
    end
    checks++;
    if (!fin) begin $display("FAIL %s timeout got no done want done", tag); errors++; end
    checks++;
    if (en_cnt !== L4) begin $display("FAIL %s en_cycles got %0d want %0d", tag, en_cnt, L4); errors++; end
    checks++;
    if (gap !== exp_gap) begin $display("FAIL %s en_gap got %0d want %0d", tag, gap, exp_gap); errors++; end
    checks++;
    if (bad_out !== 0) begin $display("FAIL %s bits got %0d wrong want 0", tag, bad_out); errors++; end
    checks++;
    if (bad_rdy !== 0) begin $display("FAIL %s word_ready got %0d wrong cycles want 0", tag, bad_rdy); errors++; end
    checks++;
    if (bad_busy !== 0) begin $display("FAIL %s busy got %0d low cycles want 0", tag, bad_busy); errors++; end
    checks++;
    if (bad_wl !== 0) begin $display("FAIL %s words_loaded_track got %0d wrong cycles want 0", tag, bad_wl); errors++; end
    @(negedge clk);
    checks++;
    if ({done4, busy4, cfg_en4} !== 3'b000) begin $display("FAIL %s after_done got done/busy/en %b want 000", tag, {done4, busy4, cfg_en4}); errors++; end
    checks++;
    if (words_loaded4 !== 3'd4) begin $display("FAIL %s words_loaded got %0d want 4", tag, words_loaded4); errors++; end
    checks++;
    if (chain4 !== exp_chain) begin $display("FAIL %s chain got %h want %h", tag, chain4, exp_chain); errors++; end
  endtask

  task automatic test_back_to_back();
    logic [CS-1:0] wv [4];
    wv[0] = 37'h0_0000_0001; wv[1] = 37'h0_0000_0002;
    wv[2] = 37'h0_0000_0004; wv[3] = 37'h0_0000_0008;
    load4(wv, -1, 0, 1'b0, "b2b");
  endtask

  task automatic test_stall();
    logic [CS-1:0] wv [4];
    wv[0] = 37'h0_0000_0001; wv[1] = 37'h0_0000_0002;
    wv[2] = 37'h0_0000_0004; wv[3] = 37'h0_0000_0008;
    load4(wv, 2, 5, 1'b1, "stall");
  endtask

  task automatic test_clear();
    logic [CS-1:0] wv [4];
    int en_cnt, noen, bad_out, rdy_seen, bad_wl, bad_busy;
    bit fin;
    for (int j = 0; j < 4; j++) wv[j] = '1;
    load4(wv, -1, 0, 1'b0, "ones");
    en_cnt = 0; noen = 0; bad_out = 0; rdy_seen = 0; bad_wl = 0; bad_busy = 0; fin = 0;
    @(negedge clk);
    clear4 = 1'b1; start4 = 1'b1; word_valid4 = 1'b1; word_data4 = 37'h1_5555_AAAA;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(negedge clk);
      clear4 = 1'b0; start4 = 1'b0;
      if (done4) begin
        fin = 1;
      end else begin
        if (busy4 !== 1'b1) bad_busy++;
        if (word_ready4) rdy_seen++;
        if (words_loaded4 !== 3'd0) bad_wl++;
        if (cfg_en4) begin
          en_cnt++;
          if (cfg_out4 !== 1'b0) bad_out++;
        end else begin
          noen++;
        end
      end
    end
    word_valid4 = 1'b0;
    checks++;
    if (!fin) begin $display("FAIL clear_timeout got no done want done"); errors++; end
    checks++;
    if (en_cnt !== L4) begin $display("FAIL clear_en_cycles got %0d want %0d", en_cnt, L4); errors++; end
    checks++;
    if (noen !== 0) begin $display("FAIL clear_en_gaps got %0d want 0", noen); errors++; end
    checks++;
    if (bad_out !== 0) begin $display("FAIL clear_out_zero got %0d ones want 0", bad_out); errors++; end
    checks++;
    if (rdy_seen !== 0) begin $display("FAIL clear_word_ready got %0d cycles want 0", rdy_seen); errors++; end
    checks++;
    if (bad_wl !== 0 || bad_busy !== 0) begin $display("FAIL clear_status got wl_bad=%0d busy_bad=%0d want 0", bad_wl, bad_busy); errors++; end
    @(negedge clk);
    checks++;
    if ({done4, busy4} !== 2'b00) begin $display("FAIL clear_done_pulse got done/busy %b want 00", {done4, busy4}); errors++; end
    checks++;
    if (chain4 !== '0) begin $display("FAIL clear_chain got %h want 0", chain4); errors++; end
  endtask

  task automatic test_reset_mid();
    logic [CS-1:0] wv [4];
    int en_cnt, acc;
    bit hit;
    wv[0] = 37'h0_1111_1111; wv[1] = 37'h0_2222_2222;
    wv[2] = 37'h1_0F0F_0F0F; wv[3] = 37'h0_ABCD_EF01;
    en_cnt = 0; acc = 0; hit = 0;
    @(negedge clk); start4 = 1'b1;
    for (int cyc = 0; cyc < 400 && !hit; cyc++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (cfg_en4 && en_cnt == CS + 10) begin
        rst4 = 1'b1; hit = 1;
      end else begin
        if (cfg_en4) en_cnt++;
        word_valid4 = (acc < 4);
        if (acc < 4) word_data4 = wv[acc];
        if (word_valid4 && word_ready4) acc++;
      end
    end
    checks++;
    if (!hit) begin $display("FAIL rstmid_reach got %0d bits want %0d", en_cnt, CS + 10); errors++; end
    @(negedge clk);
    rst4 = 1'b0; word_valid4 = 1'b0;
    checks++;
    if (cfg_en4 !== 1'b0) begin $display("FAIL rstmid_cfg_en got %b want 0", cfg_en4); errors++; end
    checks++;
    if (busy4 !== 1'b0) begin $display("FAIL rstmid_busy got %b want 0", busy4); errors++; end
    checks++;
    if (word_ready4 !== 1'b0) begin $display("FAIL rstmid_word_ready got %b want 0", word_ready4); errors++; end
    checks++;
    if (words_loaded4 !== 3'd0) begin $display("FAIL rstmid_words_loaded got %0d want 0", words_loaded4); errors++; end
    checks++;
    if (done4 !== 1'b0) begin $display("FAIL rstmid_done got %b want 0", done4); errors++; end
    load4(wv, -1, 0, 1'b0, "reload");
  endtask

  task automatic test_random();
    logic [CS-1:0] wv [4];
    logic [63:0] r64;
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < 4; j++) begin
        r64 = {$urandom(), $urandom()};
        wv[j] = r64[CS-1:0];
      end
      load4(wv, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
            1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_clear();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clb_cfg_loader.md
Name: clb_cfg_loader

Overview:
- Configuration sequencer for a daisy-chain of NUM_CLBS CLBs sharing one cfg_clk scan chain.
- Accepts one CONFIG_SIZE-bit word per CLB over a valid/ready handshake and serialises each word MSB-first onto the chain head, driving cfg_en only while real bits move.
- Also provides a clear command that flushes zeros through the whole chain.
- Sits between the bitstream source (host or ROM reader) and the first CLB's cfg_in.

Parameters:
- CONFIG_SIZE, 37: bits per CLB configuration word (scan-chain length of one CLB).
- NUM_CLBS, 4: number of CLBs chained head-to-tail.

Ports:
- cfg_clk  input  1  sole clock. The CLB chains shift on this same edge.
- reset  input  1  synchronous, active-high.
- start  input  1  begin a load session (sampled in IDLE only).
- clear  input  1  begin a zero-flush session (sampled in IDLE only).
- word_valid  input  1  word_data holds a valid configuration word.
- word_data  input  CONFIG_SIZE  configuration word; bit i ends up in that CLB's configuration bit i.
- word_ready  output  1  loader accepts word_data this cycle.
- cfg_en  output  1  shift enable to every CLB in the chain.
- cfg_out  output  1  serial data to the first CLB's cfg_in.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse when a session completes.
- words_loaded  output  $clog2(NUM_CLBS+1)  words fully shifted in the current or last session.

Behaviour:
- Reset values: state IDLE, all outputs 0, shift buffer empty, all counters 0. Reset takes effect at the next cfg_clk edge.
- States: IDLE, LOAD, CLEAR, DONE.
- IDLE:
  - clear=1 → CLEAR. Clear wins if start and clear are both 1.
  - start=1 → LOAD.
  - Both transitions clear words_loaded. All other inputs are ignored.
- LOAD, handshake and buffer:
  - word_ready = (buffer empty OR bit_cnt==CONFIG_SIZE-1) AND words accepted < NUM_CLBS.
  - A transfer occurs at a cfg_clk edge where word_valid AND word_ready. That edge loads the shift buffer and sets bit_cnt=0.
- LOAD, shifting:
  - cfg_en = buffer non-empty. cfg_out = buffer MSB. Both come directly from registers, with no combinational path from inputs.
  - Each cycle with cfg_en=1, the buffer shifts left by one and bit_cnt increments.
  - When bit_cnt==CONFIG_SIZE-1 at an edge, the word is complete: words_loaded increments, and the buffer empties unless a new word is accepted on the same edge.
  - Words accepted back-to-back produce contiguous cfg_en with no bubble. Throughput is one word per CONFIG_SIZE cycles.
- LOAD, stall and completion:
  - If the buffer is empty and word_valid=0, cfg_en=0 (stall). The chain holds and busy stays 1. A stall has no timeout.
  - The first word accepted lands in the farthest CLB (CLB NUM_CLBS-1). The last word lands in the CLB nearest the loader.
  - LOAD → DONE on the edge where words_loaded reaches NUM_CLBS.
- CLEAR:
  - cfg_en=1 and cfg_out=0 for exactly NUM_CLBS*CONFIG_SIZE consecutive cycles, counted by clr_cnt. Then → DONE.
  - word_ready=0 throughout. words_loaded stays 0.
- DONE: done=1, busy=1 for one cycle, then → IDLE. cfg_en=0.
- Ignored inputs: start or clear outside IDLE, and word_valid outside LOAD.
- Reset mid-session: the next cycle returns to IDLE with cfg_en=0. The chain is left partially shifted; software must re-run the session.
- Width rules:
  - bit_cnt is $clog2(CONFIG_SIZE) bits.
  - clr_cnt is $clog2(NUM_CLBS*CONFIG_SIZE+1) bits.
  - Counters saturate at their terminal values and never wrap inside a session.

Decomposition:
- Package clb_cfg_pkg holds:
  - localparam CLB_CONFIG_SIZE = 37
  - the state enum cfg_state_e {IDLE, LOAD, CLEAR, DONE}
  - a helper function for the chain-length constant (NUM_CLBS*CONFIG_SIZE).
- One sub-module, cfg_shift_buf: a parallel-load, MSB-out shift register with bit counter, load, shift, empty and last_bit outputs.

Test Plan:
- Single word, NUM_CLBS=1:
  - Stimulus: start, then word_data=37'h1_2345_6789 held valid.
  - Required: word_ready for 1 cycle; cfg_en high exactly 37 cycles beginning the cycle after acceptance; cfg_out equals bits 36..0 in order; done pulses the cycle after the last bit; words_loaded=1. A shadow 37-bit chain model equals 37'h1_2345_6789.
- Back-to-back, NUM_CLBS=4:
  - Stimulus: four words 37'h0_0000_0001, 37'h0_0000_0002, 37'h0_0000_0004, 37'h0_0000_0008, with valid held.
  - Required: 148 contiguous cfg_en cycles with no gap; word_ready high on the last-bit cycle of each word. Chain model: farthest CLB=...01, nearest=...08.
- Stall:
  - Stimulus: word_valid dropped for 5 cycles between words 2 and 3.
  - Required: cfg_en=0 for exactly 5 cycles; busy=1 throughout; final chain contents identical to the no-stall case.
- Clear, NUM_CLBS=4, chain preloaded with all ones:
  - Stimulus: clear.
  - Required: cfg_en=1 and cfg_out=0 for exactly 148 cycles; chain all zero; done pulse; word_ready never asserted.
- Priority and ignored inputs:
  - Stimulus: start and clear asserted together in IDLE.
  - Required: CLEAR is taken.
  - Stimulus: start asserted during LOAD.
  - Required: no effect; words_loaded unchanged.
- Reset mid-shift:
  - Stimulus: reset at bit 10 of word 2.
  - Required: the next cycle shows cfg_en=0, busy=0, word_ready=0, words_loaded=0, done=0. A following start reloads correctly from word 1.
